// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV32M multiply/divide unit: funct3 op codes,
// FSM state encoding and small decode helpers.
package muldiv_pkg;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Iteration counter width for a given operand width.
  function automatic int unsigned cnt_width(input int unsigned xlen);
    return $clog2(xlen) + 1;
  endfunction

  function automatic logic op_a_signed(input logic [2:0] op);
    return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic op_b_signed(input logic [2:0] op);
    return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// Conditional two's-complement negation on two independent lanes; used for
// operand magnitude extraction and for final result sign correction.
module muldiv_sign_fix #(
  parameter int unsigned WA = 32,
  parameter int unsigned WB = 32
) (
  input  logic [WA-1:0] a_i,
  input  logic          neg_a_i,
  input  logic [WB-1:0] b_i,
  input  logic          neg_b_i,
  output logic [WA-1:0] a_o,
  output logic [WB-1:0] b_o
);

  assign a_o = neg_a_i ? (~a_i + WA'(1)) : a_i;
  assign b_o = neg_b_i ? (~b_i + WB'(1)) : b_i;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit with start/busy/done handshake,
// flush, one-cycle divide corner cases and an optional single-cycle multiply.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned MUL_FAST = 0
) (
  input  logic            clk_w_i,
  input  logic            rst_w_i_l,
  input  logic            start_w_i_h,
  input  logic            flush_w_i_h,
  input  logic [2:0]      op_w_i,
  input  logic [XLEN-1:0] a_data_w_i,
  input  logic [XLEN-1:0] b_data_w_i,
  output logic            busy_w_o_h,
  output logic            done_w_o_h,
  output logic [XLEN-1:0] res_w_o
);

  localparam int unsigned CW = cnt_width(XLEN);

  state_e              state_q, state_d;
  logic [2:0]          op_q, op_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [XLEN-1:0]     b_q, b_d;
  logic                neg_q, neg_d;
  logic                neg_rem_q, neg_rem_d;
  logic [XLEN-1:0]     result_q, result_d;
  logic [XLEN-1:0]     res_q, res_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic                a_neg, b_neg;
  logic [XLEN-1:0]     a_mag, b_mag;
  logic                accept, is_div_in, div_zero, div_ovf;
  logic [XLEN:0]       mul_sum, div_shl, div_diff;
  logic [XLEN-1:0]     mul_addend;
  logic [2*XLEN-1:0]   mul_next, div_next, prod;
  logic [2*XLEN-1:0]   fixed_main;
  logic [XLEN-1:0]     fixed_rem, fix_res;

  assign a_neg = op_a_signed(op_w_i) & a_data_w_i[XLEN-1];
  assign b_neg = op_b_signed(op_w_i) & b_data_w_i[XLEN-1];

  muldiv_sign_fix #(.WA(XLEN), .WB(XLEN)) u_sign_in (
    .a_i     (a_data_w_i),
    .neg_a_i (a_neg),
    .b_i     (b_data_w_i),
    .neg_b_i (b_neg),
    .a_o     (a_mag),
    .b_o     (b_mag)
  );

  assign accept    = ((state_q == ST_IDLE) || (state_q == ST_DONE)) && start_w_i_h && !flush_w_i_h;
  assign is_div_in = op_w_i[2];
  assign div_zero  = (b_data_w_i == '0);
  assign div_ovf   = ((op_w_i == OP_DIV) || (op_w_i == OP_REM)) &&
                     (a_data_w_i == {1'b1, {(XLEN-1){1'b0}}}) && (b_data_w_i == '1);

  // Shift-add: acc = {partial product, remaining multiplier bits}.
  assign mul_addend = acc_q[0] ? b_q : '0;
  assign mul_sum    = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, mul_addend};
  assign mul_next   = {mul_sum, acc_q[XLEN-1:1]};

  // Restoring divide: acc = {remainder, dividend shifting out / quotient shifting in}.
  assign div_shl  = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
  assign div_diff = div_shl - {1'b0, b_q};
  assign div_next = div_diff[XLEN] ? {div_shl[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                   : {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};

  if (MUL_FAST != 0) begin : g_fast_mul
    assign prod = op_q[2] ? acc_q
                          : ({{XLEN{1'b0}}, acc_q[XLEN-1:0]} * {{XLEN{1'b0}}, b_q});
  end else begin : g_iter_mul
    assign prod = acc_q;
  end

  muldiv_sign_fix #(.WA(2*XLEN), .WB(XLEN)) u_sign_out (
    .a_i     (prod),
    .neg_a_i (neg_q),
    .b_i     (acc_q[2*XLEN-1:XLEN]),
    .neg_b_i (neg_rem_q),
    .a_o     (fixed_main),
    .b_o     (fixed_rem)
  );

  always_comb begin
    fix_res = fixed_main[XLEN-1:0];
    case (op_q)
      OP_MULH, OP_MULHSU, OP_MULHU: fix_res = fixed_main[2*XLEN-1:XLEN];
      OP_REM, OP_REMU:              fix_res = fixed_rem;
      default:                      fix_res = fixed_main[XLEN-1:0];
    endcase
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    b_d       = b_q;
    neg_d     = neg_q;
    neg_rem_d = neg_rem_q;
    result_d  = result_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (accept) begin
          op_d      = op_w_i;
          b_d       = b_mag;
          acc_d     = {{XLEN{1'b0}}, a_mag};
          cnt_d     = '0;
          neg_d     = a_neg ^ b_neg;
          neg_rem_d = a_neg;
          if (is_div_in && div_zero) begin
            result_d = op_w_i[1] ? a_data_w_i : '1;
            state_d  = ST_DONE;
          end else if (div_ovf) begin
            result_d = op_w_i[1] ? '0 : a_data_w_i;
            state_d  = ST_DONE;
          end else if (!is_div_in && (MUL_FAST != 0)) begin
            state_d = ST_FIX;
          end else begin
            state_d = ST_CALC;
          end
        end
      end
      ST_CALC: begin
        cnt_d = cnt_q + CW'(1);
        acc_d = op_q[2] ? div_next : mul_next;
        if (cnt_q == CW'(XLEN-1)) state_d = ST_FIX;
      end
      ST_FIX: begin
        result_d = fix_res;
        state_d  = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (flush_w_i_h) state_d = ST_IDLE;
  end

  // Outputs are registered one stage behind the state, so DONE is the cycle
  // that loads done/res and a start in that cycle overlaps the done pulse.
  assign busy_d = (state_d == ST_CALC) || (state_d == ST_FIX);
  assign done_d = (state_q == ST_DONE) && !flush_w_i_h;
  assign res_d  = done_d ? result_q : res_q;

  always_ff @(posedge clk_w_i) begin
    if (!rst_w_i_l) begin
      state_q   <= ST_IDLE;
      op_q      <= '0;
      cnt_q     <= '0;
      acc_q     <= '0;
      b_q       <= '0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= '0;
      res_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      b_q       <= b_d;
      neg_q     <= neg_d;
      neg_rem_q <= neg_rem_d;
      result_q  <= result_d;
      res_q     <= res_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign busy_w_o_h = busy_q;
  assign done_w_o_h = done_q;
  assign res_w_o    = res_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit: an iterative instance and a
// single-cycle-multiply instance share operands but have separate start lines.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst_l = 1'b0;
  logic        start_s = 1'b0, start_f = 1'b0;
  logic        flush_s = 1'b0, flush_f = 1'b0;
  logic [2:0]  op_i = '0;
  logic [31:0] a_i = '0, b_i = '0;
  logic        busy_s, done_s, busy_f, done_f;
  logic [31:0] res_s, res_f;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  always #5 clk = ~clk;

  muldiv_unit #(.XLEN(32), .MUL_FAST(0)) dut (
    .clk_w_i(clk), .rst_w_i_l(rst_l), .start_w_i_h(start_s), .flush_w_i_h(flush_s),
    .op_w_i(op_i), .a_data_w_i(a_i), .b_data_w_i(b_i),
    .busy_w_o_h(busy_s), .done_w_o_h(done_s), .res_w_o(res_s)
  );

  muldiv_unit #(.XLEN(32), .MUL_FAST(1)) dut_fast (
    .clk_w_i(clk), .rst_w_i_l(rst_l), .start_w_i_h(start_f), .flush_w_i_h(flush_f),
    .op_w_i(op_i), .a_data_w_i(a_i), .b_data_w_i(b_i),
    .busy_w_o_h(busy_f), .done_w_o_h(done_f), .res_w_o(res_f)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one op and waits (bounded) for done; lat = edges from accept to done, 0 on timeout.
  task automatic run_op(input bit fast, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, output logic [31:0] res, output int lat,
                        output int busy_n);
    op_i = op; a_i = a; b_i = b;
    if (fast) start_f = 1'b1; else start_s = 1'b1;
    tick();
    start_f = 1'b0; start_s = 1'b0;
    lat = 0; busy_n = 0; res = 'x;
    for (int n = 1; n <= 60; n++) begin
      if (fast ? busy_f : busy_s) busy_n++;
      tick();
      if (fast ? done_f : done_s) begin
        lat = n;
        res = fast ? res_f : res_s;
        break;
      end
    end
  endtask

  task automatic test_reset();
    repeat (2) tick();
    tests++;
    if ({busy_s, done_s, res_s} !== 34'd0) begin
      fails++; $display("FAIL reset_slow got busy=%b done=%b res=%h exp 0/0/0", busy_s, done_s, res_s);
    end
    tests++;
    if ({busy_f, done_f, res_f} !== 34'd0) begin
      fails++; $display("FAIL reset_fast got busy=%b done=%b res=%h exp 0/0/0", busy_f, done_f, res_f);
    end
    rst_l = 1'b1;
    tick();
  endtask

  task automatic test_iterative();
    vec_t v[8] = '{
      '{OP_MUL,    32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB, 34},
      '{OP_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 34},
      '{OP_MULHU,  32'h80000000, 32'h80000000, 32'h40000000, 34},
      '{OP_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 34},
      '{OP_DIV,    32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 34},
      '{OP_REM,    32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 34},
      '{OP_DIVU,   32'h00000007, 32'h00000002, 32'h00000003, 34},
      '{OP_REMU,   32'h00000007, 32'h00000002, 32'h00000001, 34}
    };
    logic [31:0] r;
    int l, bn;
    for (int i = 0; i < 8; i++) begin
      run_op(1'b0, v[i].op, v[i].a, v[i].b, r, l, bn);
      tests++;
      if (r !== v[i].exp) begin
        fails++; $display("FAIL iter_res[%0d] got %h exp %h", i, r, v[i].exp);
      end
      tests++;
      if (l != v[i].lat) begin
        fails++; $display("FAIL iter_lat[%0d] got %0d exp %0d", i, l, v[i].lat);
      end
      tests++;
      if (bn != 33 || busy_s !== 1'b0) begin
        fails++; $display("FAIL iter_busy[%0d] got cycles=%0d busy_at_done=%b exp 33/0", i, bn, busy_s);
      end
      tick();
      tests++;
      if (done_s !== 1'b0) begin
        fails++; $display("FAIL iter_done_pulse[%0d] got %b exp 0", i, done_s);
      end
    end
  endtask

  task automatic test_fast_mul();
    vec_t v[5] = '{
      '{OP_MUL,    32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB, 2},
      '{OP_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 2},
      '{OP_MULHU,  32'h80000000, 32'h80000000, 32'h40000000, 2},
      '{OP_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 2},
      '{OP_DIV,    32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 34}
    };
    logic [31:0] r;
    int l, bn;
    for (int i = 0; i < 5; i++) begin
      run_op(1'b1, v[i].op, v[i].a, v[i].b, r, l, bn);
      tests++;
      if (r !== v[i].exp) begin
        fails++; $display("FAIL fast_res[%0d] got %h exp %h", i, r, v[i].exp);
      end
      tests++;
      if (l != v[i].lat) begin
        fails++; $display("FAIL fast_lat[%0d] got %0d exp %0d", i, l, v[i].lat);
      end
      tick();
    end
  endtask

  task automatic test_div_special();
    vec_t v[5] = '{
      '{OP_DIV,  32'h00001234, 32'h00000000, 32'hFFFFFFFF, 1},
      '{OP_REM,  32'h00001234, 32'h00000000, 32'h00001234, 1},
      '{OP_DIVU, 32'h00001234, 32'h00000000, 32'hFFFFFFFF, 1},
      '{OP_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1},
      '{OP_REM,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1}
    };
    logic [31:0] r;
    int l, bn;
    for (int i = 0; i < 5; i++) begin
      run_op(1'b0, v[i].op, v[i].a, v[i].b, r, l, bn);
      tests++;
      if (r !== v[i].exp) begin
        fails++; $display("FAIL special_res[%0d] got %h exp %h", i, r, v[i].exp);
      end
      tests++;
      if (l != v[i].lat) begin
        fails++; $display("FAIL special_lat[%0d] got %0d exp %0d", i, l, v[i].lat);
      end
      tick();
    end
  endtask

  task automatic test_start_while_busy();
    logic [31:0] r;
    int l, seen;
    op_i = OP_DIVU; a_i = 32'd100; b_i = 32'd7; start_s = 1'b1;
    tick();
    start_s = 1'b0;
    repeat (4) tick();
    op_i = OP_MUL; a_i = 32'd3; b_i = 32'd3; start_s = 1'b1;
    tick();
    start_s = 1'b0;
    l = 0; r = 'x;
    for (int n = 6; n <= 60; n++) begin
      tick();
      if (done_s) begin l = n; r = res_s; break; end
    end
    tests++;
    if (r !== 32'd14 || l != 34) begin
      fails++; $display("FAIL busy_start got res=%h lat=%0d exp 0000000e/34", r, l);
    end
    seen = 0;
    repeat (40) begin
      tick();
      if (done_s) seen++;
    end
    tests++;
    if (seen != 0) begin
      fails++; $display("FAIL busy_start_extra_done got %0d exp 0", seen);
    end
  endtask

  task automatic test_flush();
    logic [31:0] r;
    int l, bn, seen;
    run_op(1'b0, OP_DIVU, 32'd7, 32'd2, r, l, bn);
    tick();
    op_i = OP_DIVU; a_i = 32'd100; b_i = 32'd7; start_s = 1'b1;
    tick();
    start_s = 1'b0;
    repeat (4) tick();
    op_i = OP_MUL; a_i = 32'd3; b_i = 32'd3; start_s = 1'b1;
    tick();
    start_s = 1'b0;
    repeat (4) tick();
    flush_s = 1'b1;
    tick();
    flush_s = 1'b0;
    tick();
    tests++;
    if (busy_s !== 1'b0) begin
      fails++; $display("FAIL flush_busy got %b exp 0", busy_s);
    end
    seen = 0;
    repeat (40) begin
      if (done_s || busy_s) seen++;
      tick();
    end
    tests++;
    if (seen != 0 || res_s !== 32'd3) begin
      fails++; $display("FAIL flush_quiet got activity=%0d res=%h exp 0/00000003", seen, res_s);
    end
    op_i = OP_DIVU; a_i = 32'd100; b_i = 32'd7; start_s = 1'b1; flush_s = 1'b1;
    tick();
    start_s = 1'b0; flush_s = 1'b0;
    tests++;
    if (busy_s !== 1'b0) begin
      fails++; $display("FAIL flush_start_busy got %b exp 0", busy_s);
    end
    seen = 0;
    repeat (40) begin
      if (done_s) seen++;
      tick();
    end
    tests++;
    if (seen != 0 || res_s !== 32'd3) begin
      fails++; $display("FAIL flush_start_quiet got dones=%0d res=%h exp 0/00000003", seen, res_s);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] r1, r2;
    int l1, l2;
    op_i = OP_DIVU; a_i = 32'd7; b_i = 32'd2; start_s = 1'b1;
    tick();
    a_i = 32'd100; b_i = 32'd7;
    l1 = 0; r1 = 'x;
    for (int n = 1; n <= 40; n++) begin
      tick();
      if (done_s) begin l1 = n; r1 = res_s; break; end
    end
    start_s = 1'b0;
    tests++;
    if (r1 !== 32'd3 || l1 != 34 || busy_s !== 1'b1) begin
      fails++; $display("FAIL b2b_first got res=%h lat=%0d busy=%b exp 00000003/34/1", r1, l1, busy_s);
    end
    l2 = 0; r2 = 'x;
    for (int n = 1; n <= 40; n++) begin
      tick();
      if (done_s) begin l2 = n; r2 = res_s; break; end
    end
    tests++;
    if (r2 !== 32'd14 || l2 != 34) begin
      fails++; $display("FAIL b2b_second got res=%h lat=%0d exp 0000000e/34", r2, l2);
    end
    tick();
  endtask

  task automatic test_reset_in_calc();
    logic [31:0] r;
    int l, bn;
    op_i = OP_DIVU; a_i = 32'd100; b_i = 32'd7; start_s = 1'b1; flush_s = 1'b0;
    tick();
    start_s = 1'b0;
    repeat (5) tick();
    rst_l = 1'b0; start_s = 1'b1; flush_s = 1'b1;
    tick();
    start_s = 1'b0; flush_s = 1'b0;
    tests++;
    if ({busy_s, done_s, res_s} !== 34'd0) begin
      fails++; $display("FAIL reset_calc got busy=%b done=%b res=%h exp 0/0/0", busy_s, done_s, res_s);
    end
    rst_l = 1'b1;
    tick();
    run_op(1'b0, OP_DIVU, 32'd100, 32'd7, r, l, bn);
    tests++;
    if (r !== 32'd14 || l != 34) begin
      fails++; $display("FAIL reset_recover got res=%h lat=%0d exp 0000000e/34", r, l);
    end
  endtask

  initial begin
    test_reset();
    test_iterative();
    test_fast_mul();
    test_div_special();
    test_start_while_busy();
    test_flush();
    test_back_to_back();
    test_reset_in_calc();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
